pixel_denormalizer: RTL
=======================

# pixel_denormalizer

Streaming inverse of the min-max pixel normalizer. It takes a full-scale normalized frame (0 to 2^DATA_WIDTH-1), one pixel per cycle in raster order, and maps each pixel back into the original [min_val, max_val] range. Output carries row/column tags and a frame-end marker. It sits after the normalized-domain processing stages and restores pixel intensities before writeback.

## Interface
- DATA_WIDTH, 8, pixel width in bits
- ROWS, 128, frame height
- COLS, 128, frame width
- clk  input  1  clock, all logic rising-edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  begin a frame; sampled only in IDLE or DONE
- min_val  input  DATA_WIDTH  lower bound of target range; latched on accepted start
- max_val  input  DATA_WIDTH  upper bound of target range; latched on accepted start
- in_valid  input  1  in_pixel valid
- in_ready  output  1  block accepts in_pixel this cycle
- in_pixel  input  DATA_WIDTH  normalized pixel, raster order
- out_valid  output  1  out_pixel valid
- out_ready  input  1  downstream accepts out_pixel
- out_pixel  output  DATA_WIDTH  denormalized pixel
- out_row  output  $clog2(ROWS)  row of out_pixel
- out_col  output  $clog2(COLS)  column of out_pixel
- out_last  output  1  out_pixel is the final pixel of the frame
- busy  output  1  state is RUN or DRAIN
- done  output  1  frame fully emitted; held until next accepted start
- err_range  output  1  latched max_val < min_val for the current frame

## Operation
- FSM states:
  - IDLE: start moves to RUN.
  - RUN: accept pixels until ROWS*COLS have been taken, then move to DRAIN.
  - DRAIN: on the out handshake with out_last, move to DONE.
  - DONE: start moves to RUN.
- On an accepted start, latch min_val and max_val, clear the input counter, row counter and column counter, clear done, and set err_range = (max_val < min_val).
- start is ignored in RUN and DRAIN.
- range = max_val - min_val when max_val >= min_val; otherwise range = 0. Range is DATA_WIDTH bits and unsigned.
- Stage 1: prod = in_pixel * range, 2*DATA_WIDTH bits.
- Stage 2: q = (prod + 2^(DATA_WIDTH-1) - 1) / (2^DATA_WIDTH - 1), a rounded divide by the full-scale constant. Then out_pixel = min_lat + q. The result never exceeds max_lat, so no overflow or saturation is needed.
- When max == min, or err_range is set, every output equals min_lat.
- Out tags come from an output-side raster counter. It increments on each out handshake: col wraps at COLS-1 to 0 and row increments. out_last = (row == ROWS-1 && col == COLS-1).
- in_ready = (state == RUN) && !stall && (input count < ROWS*COLS).
- stall = out_valid && !out_ready.
- Backpressure stalls the whole pipeline: stage registers and valid bits hold while stall is high. Pipeline bubbles are preserved.
- Reset mid-frame:
  - All outputs go low immediately and the FSM goes to IDLE.
  - Pipeline contents are discarded and the counters clear.
  - A new start is then required.

## Timing
- Reset values:
  - in_ready, out_valid, out_last, busy, done, err_range = 0.
  - out_pixel, out_row, out_col = 0.
  - State = IDLE.
- start high in cycle N (IDLE or DONE): state = RUN, busy = 1 and in_ready = 1 in cycle N+1.
- Input handshake in cycle k with no stall: out_valid is high in cycle k+2 with that pixel. Latency is fixed at 2 cycles.
- Throughput is 1 pixel/cycle with out_ready held high.
- out_valid, out_pixel and the tags stay stable while out_valid && !out_ready.
- The last input handshake moves the FSM to DRAIN the next cycle; in_ready stays 0 from then on.
- Out handshake with out_last in cycle m: done = 1 and busy = 0 in cycle m+1, and out_valid = 0 in cycle m+1.
- start in the same cycle as the final out handshake is ignored, because the FSM is still in DRAIN.
- in_valid while in_ready = 0 has no effect.

## Test plan
- DATA_WIDTH=8, min=50, max=150, inputs 0, 64, 128, 255 -> outputs 50, 75, 100, 150, each 2 cycles after its input handshake.
- min=max=77, arbitrary inputs -> every output is 77; err_range = 0.
- min=200, max=10 -> err_range = 1 from the cycle after start; every output is 200; frame completes normally.
- ROWS=2, COLS=2, out_ready held high, 4 inputs back-to-back:
  - tags run (0,0), (0,1), (1,0), (1,1).
  - out_last is set only on the 4th output.
  - done rises 1 cycle after the 4th handshake, and in_ready drops after the 4th input.
- out_ready low for 3 cycles mid-stream -> out_pixel and tags held stable, in_ready = 0 during the stall, no pixel lost or duplicated; the output sequence matches the no-stall run.
- Assert reset after 2 of 4 inputs, then start with min=0, max=255 and inputs equal to their index -> all outputs cleared at reset; new frame outputs are 0, 1, 2, 3 with tags restarting at (0,0).

Source files
------------

// File: rtl/pixel_denormalizer_if.sv
// ---------------------------------------------------------------------------
// pixel_denormalizer_if : stream, control and status bundle for pixel_denormalizer
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface pixel_denormalizer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 128,
  parameter int COLS       = 128
);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

  logic                  start;
  logic [DATA_WIDTH-1:0] min_val;
  logic [DATA_WIDTH-1:0] max_val;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_pixel;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_pixel;
  logic [ROW_W-1:0]      out_row;
  logic [COL_W-1:0]      out_col;
  logic                  out_last;
  logic                  busy;
  logic                  done;
  logic                  err_range;

  modport master (
    output start, min_val, max_val, in_valid, in_pixel, out_ready,
    input  in_ready, out_valid, out_pixel, out_row, out_col, out_last,
           busy, done, err_range
  );

  modport slave (
    input  start, min_val, max_val, in_valid, in_pixel, out_ready,
    output in_ready, out_valid, out_pixel, out_row, out_col, out_last,
           busy, done, err_range
  );
endinterface

`default_nettype wire

// File: rtl/pixel_denormalizer.sv
// ---------------------------------------------------------------------------
// pixel_denormalizer : maps a full-scale normalized frame back into [min,max]
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module pixel_denormalizer #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 128,
  parameter int COLS       = 128
) (
  input  wire logic           clk,
  input  wire logic           reset,
  pixel_denormalizer_if.slave bus
);
  localparam int PIXELS = ROWS * COLS;
  localparam int CNT_W  = $clog2(PIXELS + 1);
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int PROD_W = 2 * DATA_WIDTH;

  localparam logic [PROD_W:0] FULL_SCALE =
    {{(PROD_W + 1 - DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};
  localparam logic [PROD_W:0] HALF_M1 =
    {{(PROD_W + 2 - DATA_WIDTH){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] min_lat;
  logic [DATA_WIDTH-1:0] range_lat;
  logic                  err_lat;
  logic                  busy_r;
  logic                  done_r;
  logic [CNT_W-1:0]      in_count;

  logic                  s1_valid;
  logic [PROD_W-1:0]     s1_prod;
  logic                  out_valid_r;
  logic [DATA_WIDTH-1:0] out_pixel_r;
  logic [ROW_W-1:0]      row_r;
  logic [COL_W-1:0]      col_r;

  logic stall;
  logic in_ready;
  logic in_fire;
  logic out_fire;
  logic at_last;
  logic start_ok;

  assign stall    = out_valid_r && !bus.out_ready;
  assign in_ready = (state == RUN) && !stall && (in_count < CNT_W'(PIXELS));
  assign in_fire  = in_ready && bus.in_valid;
  assign out_fire = out_valid_r && bus.out_ready;
  assign at_last  = out_valid_r && (row_r == ROW_W'(ROWS - 1)) &&
                    (col_r == COL_W'(COLS - 1));
  assign start_ok = bus.start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      min_lat   <= '0;
      range_lat <= '0;
      err_lat   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            state   <= RUN;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            min_lat <= bus.min_val;
            err_lat <= (bus.max_val < bus.min_val);
            // An inverted range collapses to zero so every pixel lands on min.
            range_lat <= (bus.max_val >= bus.min_val) ?
                         (bus.max_val - bus.min_val) : '0;
          end
        end
        RUN: begin
          if (in_fire && (in_count == CNT_W'(PIXELS - 1))) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_fire && at_last) begin
            state  <= DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_count <= '0;
    end else if (start_ok) begin
      in_count <= '0;
    end else if (in_fire) begin
      in_count <= in_count + 1'b1;
    end
  end

  // Two-stage datapath; everything freezes while the output is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      s1_prod     <= '0;
      out_valid_r <= 1'b0;
      out_pixel_r <= '0;
    end else if (!stall) begin
      s1_valid    <= in_fire;
      out_valid_r <= s1_valid;
      if (in_fire) begin
        s1_prod <= PROD_W'(bus.in_pixel) * PROD_W'(range_lat);
      end
      if (s1_valid) begin
        out_pixel_r <= min_lat +
                       DATA_WIDTH'(({1'b0, s1_prod} + HALF_M1) / FULL_SCALE);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_r <= '0;
      col_r <= '0;
    end else if (start_ok) begin
      row_r <= '0;
      col_r <= '0;
    end else if (out_fire) begin
      if (col_r == COL_W'(COLS - 1)) begin
        col_r <= '0;
        row_r <= (row_r == ROW_W'(ROWS - 1)) ? '0 : row_r + 1'b1;
      end else begin
        col_r <= col_r + 1'b1;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_r;
  assign bus.out_pixel = out_pixel_r;
  assign bus.out_row   = row_r;
  assign bus.out_col   = col_r;
  assign bus.out_last  = at_last;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.err_range = err_lat;

endmodule

`default_nettype wire
